// File: rtl/branch_hazard_ctrl_if.sv
// Bundle of the signals exchanged between the pipeline datapath and the
// branch/hazard sequencer. The datapath side is the master (it supplies
// the IF/ID and ID/EX instructions and the brcomp decision). The sequencer
// side is the slave (it returns the redirect, stall, flush and valid
// controls).
interface branch_hazard_ctrl_if;
  logic [31:0] id_instr_i;
  logic [31:0] ex_instr_i;
  logic        br_sel_i;
  logic        pc_sel_o;
  logic        stall_pc_o;
  logic        stall_ifid_o;
  logic        flush_ifid_o;
  logic        flush_idex_o;
  logic        ex_valid_o;
  logic [1:0]  ctrl_state_o;

  modport master (
    output id_instr_i, ex_instr_i, br_sel_i,
    input  pc_sel_o, stall_pc_o, stall_ifid_o, flush_ifid_o, flush_idex_o,
           ex_valid_o, ctrl_state_o
  );

  modport slave (
    input  id_instr_i, ex_instr_i, br_sel_i,
    output pc_sel_o, stall_pc_o, stall_ifid_o, flush_ifid_o, flush_idex_o,
           ex_valid_o, ctrl_state_o
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Pipeline sequencer for branch redirect/flush and load-use stalls.
// Tracks IF/ID and ID/EX valid bits so bubbles never act as taken branches.
// Optional BRCTRL_PERF_EN adds taken-redirect and stall-cycle counters.
module branch_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  branch_hazard_ctrl_if.slave bus
`ifdef BRCTRL_PERF_EN
  ,
  output logic [31:0]         taken_cnt_o,
  output logic [31:0]         stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10
  } state_e;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  state_e     state_q;
  logic       id_valid_q;
  logic       ex_valid_q;
  logic [1:0] cnt_q;

  logic [4:0] id_opc, ex_opc, ex_rd, id_rs1, id_rs2;
  logic       id_rs1_used, id_rs2_used;
  logic       taken, hazard;
  logic       pc_sel, stall_pc, stall_ifid, flush_ifid, flush_idex;

  // Decode the register fields and derive the taken and load-use conditions
  always_comb begin
    id_opc      = bus.id_instr_i[6:2];
    ex_opc      = bus.ex_instr_i[6:2];
    ex_rd       = bus.ex_instr_i[11:7];
    id_rs1      = bus.id_instr_i[19:15];
    id_rs2      = bus.id_instr_i[24:20];
    id_rs1_used = !(id_opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    id_rs2_used = id_opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    taken       = ex_valid_q & bus.br_sel_i;
    hazard      = ex_valid_q & id_valid_q & (ex_opc == OPC_LOAD) & (ex_rd != 5'd0) &
                  (((ex_rd == id_rs1) & id_rs1_used) | ((ex_rd == id_rs2) & id_rs2_used));
  end

  // Pipeline controls; taken wins over a simultaneous load-use hazard
  always_comb begin
    pc_sel     = 1'b0;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    unique case (state_q)
      RUN: begin
        if (taken) begin
          pc_sel     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (hazard) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end
      LU_STALL: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state, stall counter and per-stage valid tracking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      id_valid_q <= 1'b0;
      ex_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      id_valid_q <= flush_ifid ? 1'b0 : (stall_ifid ? id_valid_q : 1'b1);
      ex_valid_q <= flush_idex ? 1'b0 : id_valid_q;
      unique case (state_q)
        RUN: begin
          if (taken) begin
            state_q <= FLUSH;
          end else if (hazard) begin
            // The RUN cycle that detects the hazard is the first bubble,
            // so only LU_STALL_CYCLES-1 further cycles are spent in LU_STALL.
            cnt_q   <= 2'(LU_STALL_CYCLES - 1);
            state_q <= (LU_STALL_CYCLES > 1) ? LU_STALL : RUN;
          end
        end
        LU_STALL: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_q <= RUN;
        end
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pc_sel_o     = pc_sel;
  assign bus.stall_pc_o   = stall_pc;
  assign bus.stall_ifid_o = stall_ifid;
  assign bus.flush_ifid_o = flush_ifid;
  assign bus.flush_idex_o = flush_idex;
  assign bus.ex_valid_o   = ex_valid_q;
  assign bus.ctrl_state_o = state_q;

`ifdef BRCTRL_PERF_EN
  logic [31:0] taken_cnt_q, stall_cnt_q;

  // Event counters for redirects and stalled cycles, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_q + {31'd0, pc_sel};
      stall_cnt_q <= stall_cnt_q + {31'd0, stall_pc};
    end
  end

  assign taken_cnt_o = taken_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
